// File: rtl/xnor_gate.sv
// Bitwise two-operand XNOR leaf gate with a combinational all-equal flag and a
// clocked side path (registered result, registered flag, saturating match counter).
module xnor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] c,
    output logic             eq,
    output logic [WIDTH-1:0] c_q,
    output logic             eq_q,
    output logic [CNT_W-1:0] match_cnt
);

    // Holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v;
        if (!(&v)) r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    logic [WIDTH-1:0] c_p1;
    logic             eq_p1;
    logic [CNT_W-1:0] cnt_p1;

    assign c  = ~(a ^ b);
    assign eq = &c;

    // Stage p0 -> p1: one-cycle registered copy of the combinational result.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_p1   <= '0;
            eq_p1  <= 1'b0;
            cnt_p1 <= '0;
        end else if (en) begin
            c_p1  <= c;
            eq_p1 <= eq;
            if (eq) cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign c_q       = c_p1;
    assign eq_q      = eq_p1;
    assign match_cnt = cnt_p1;

endmodule

// File: tb/tb_xnor_gate.sv
// Self-checking bench for xnor_gate: WIDTH=1 truth table, WIDTH=8 registered
// path with an 8-bit counter, and a 2-bit counter instance for saturation.
module tb_xnor_gate;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       eq;
    } vec_t;

    typedef struct {
        logic [7:0] c_q;
        logic       eq_q;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance, clock idle
    logic       clk1 = 1'b0;
    logic       rst1 = 1'b0;
    logic       en1  = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [0:0] c1, c_q1;
    logic       eq1, eq_q1;
    logic [7:0] cnt1;

    // WIDTH=8 instances sharing stimulus
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] c8, c_q8, c2, c_q2;
    logic       eq8, eq_q8, eq2, eq_q2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    xnor_gate #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk1), .rst(rst1), .a(a1), .b(b1), .en(en1),
        .c(c1), .eq(eq1), .c_q(c_q1), .eq_q(eq_q1), .match_cnt(cnt1)
    );

    xnor_gate #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
        .c(c8), .eq(eq8), .c_q(c_q8), .eq_q(eq_q8), .match_cnt(cnt8)
    );

    xnor_gate #(.WIDTH(8), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
        .c(c2), .eq(eq2), .c_q(c_q2), .eq_q(eq_q2), .match_cnt(cnt2)
    );

    exp_t sb[$];

    // Reference state of the registered path
    logic [7:0] m_cq   = '0;
    logic       m_eq   = 1'b0;
    logic [7:0] m_cnt8 = '0;
    logic [1:0] m_cnt2 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] av, input logic [7:0] bv);
        exp_t       x;
        logic [7:0] xc;
        logic       xeq;
        xc  = 8'h00;
        for (int i = 0; i < 8; i++) xc[i] = (av[i] == bv[i]);
        xeq = (av == bv);
        @(negedge clk);
        rst = r; en = e; a8 = av; b8 = bv;
        #1;
        check("c8_comb", {24'd0, c8}, {24'd0, xc});
        check("eq8_comb", {31'd0, eq8}, {31'd0, xeq});
        check("c2_comb", {24'd0, c2}, {24'd0, xc});
        check("eq2_comb", {31'd0, eq2}, {31'd0, xeq});
        if (r) begin
            m_cq = 8'h00; m_eq = 1'b0; m_cnt8 = 8'h00; m_cnt2 = 2'd0;
        end else if (e) begin
            m_cq = xc; m_eq = xeq;
            if (xeq) begin
                if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
                if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
            end
        end
        x.c_q = m_cq; x.eq_q = m_eq; x.cnt8 = m_cnt8; x.cnt2 = m_cnt2;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            x = sb.pop_front();
            check("c_q8", {24'd0, c_q8}, {24'd0, x.c_q});
            check("eq_q8", {31'd0, eq_q8}, {31'd0, x.eq_q});
            check("cnt8", {24'd0, cnt8}, {24'd0, x.cnt8});
            check("c_q2", {24'd0, c_q2}, {24'd0, x.c_q});
            check("eq_q2", {31'd0, eq_q2}, {31'd0, x.eq_q});
            check("cnt2", {30'd0, cnt2}, {30'd0, x.cnt2});
        end
    endtask

    vec_t t1[4];
    vec_t t8[5];
    logic [1:0] sat_seq[6];

    initial begin
        t1[0] = '{8'h00, 8'h00, 8'h01, 1'b1};
        t1[1] = '{8'h00, 8'h01, 8'h00, 1'b0};
        t1[2] = '{8'h01, 8'h00, 8'h00, 1'b0};
        t1[3] = '{8'h01, 8'h01, 8'h01, 1'b1};
        t8[0] = '{8'hA5, 8'hA5, 8'hFF, 1'b1};
        t8[1] = '{8'hF0, 8'h0F, 8'h00, 1'b0};
        t8[2] = '{8'hFF, 8'h00, 8'h00, 1'b0};
        t8[3] = '{8'h3C, 8'h35, 8'hF6, 1'b0};
        t8[4] = '{8'h80, 8'h00, 8'h7F, 1'b0};
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        // WIDTH=1 truth table, clock idle, each pattern held 5 time units
        foreach (t1[i]) begin
            a1 = t1[i].a[0:0];
            b1 = t1[i].b[0:0];
            #1;
            check("w1_c", {31'd0, c1}, {31'd0, t1[i].c[0]});
            check("w1_eq", {31'd0, eq1}, {31'd0, t1[i].eq});
            #4;
        end

        // WIDTH=8 combinational vectors with registers under reset
        foreach (t8[i]) begin
            @(negedge clk);
            rst = 1'b1; en = 1'b0; a8 = t8[i].a; b8 = t8[i].b;
            #1;
            check("w8_c", {24'd0, c8}, {24'd0, t8[i].c});
            check("w8_eq", {31'd0, eq8}, {31'd0, t8[i].eq});
        end

        // Reset state, then match, then mismatch
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'hA5, 8'hA5);
        check("after_match_cnt", {24'd0, cnt8}, 32'd1);
        check("after_match_cq", {24'd0, c_q8}, 32'hFF);
        step(1'b0, 1'b1, 8'hF0, 8'h0F);
        check("after_mismatch_cnt", {24'd0, cnt8}, 32'd1);
        check("after_mismatch_eqq", {31'd0, eq_q8}, 32'd0);

        // en=0: registers hold while inputs change
        for (int i = 0; i < 4; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            step(1'b0, 1'b0, r, (i % 2 == 0) ? r : ~r);
        end

        // Saturation of the 2-bit counter
        step(1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h5A, 8'h5A);
            check("sat_seq", {30'd0, cnt2}, {30'd0, sat_seq[i]});
        end

        // Reset mid-operation with en=1 and a==b
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h11, 8'h11);
        step(1'b0, 1'b1, 8'h22, 8'h22);
        check("pre_rst_cnt", {30'd0, cnt2}, 32'd2);
        step(1'b1, 1'b1, 8'h33, 8'h33);
        check("rst_cnt", {24'd0, cnt8}, 32'd0);
        check("rst_cq", {24'd0, c_q8}, 32'd0);
        check("rst_c_comb", {24'd0, c8}, 32'hFF);
        step(1'b1, 1'b1, 8'h44, 8'h44);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? ra : 8'($urandom);
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xnor_gate.md
Name: xnor_gate

Overview:
- Parameterizable bitwise two-operand XNOR (equality-per-bit) block.
- Primary path is purely combinational (c = a XNOR b). It is used as a leaf gate wherever the design needs bit equality.
- A clocked side path provides:
  - a registered copy of the result,
  - an all-bits-equal flag,
  - a saturating match counter, for pipelined consumers and debug.

Parameters:
- WIDTH, 1, operand/result width in bits (>=1).
- CNT_W, 8, width of match_cnt (>=1).

Ports:
- clk  input  1  rising-edge clock for registered outputs only.
- rst  input  1  synchronous, active-high reset for registered outputs only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- en  input  1  register update enable; sampled at rising clk.
- c  output  WIDTH  combinational bitwise XNOR, ~(a ^ b).
- eq  output  1  combinational all-bits-equal flag, &c.
- c_q  output  WIDTH  registered c.
- eq_q  output  1  registered eq.
- match_cnt  output  CNT_W  count of enabled cycles with eq=1, saturating.

Behaviour:
- Combinational path:
  - c[i] = ~(a[i] ^ b[i]) for every bit i.
  - Zero latency; follows any input change within the same delta.
  - Independent of clk, rst and en.
- WIDTH=1 truth table (a,b -> c): 0,0->1; 0,1->0; 1,0->0; 1,1->1.
- eq = reduction-AND of c, i.e. 1 iff a == b across all WIDTH bits.
- X/Z on any input bit gives X on the corresponding c bit (standard operator semantics). No special X handling.
- Registered path, evaluated at each rising clk, in priority order:
  1. rst=1: c_q <= 0, eq_q <= 0, match_cnt <= 0. rst overrides en.
  2. en=1: c_q <= c, eq_q <= eq. match_cnt increments by 1 if eq=1, unless it is already all-ones, in which case it holds (saturates, no wrap).
  3. en=0: all registers hold.
- Registered latency is exactly 1 clock from the sampled inputs.
- Reset mid-operation: registers clear on the first rising edge with rst=1 and stay cleared while rst is high. c and eq continue to track the inputs during reset.
- No power-on default is required before the first reset edge. Registered outputs are undefined until reset is applied.
- No handshake or backpressure; en is a plain qualifier.

Test Plan:
- WIDTH=1, clk idle, stimulus (a,b) = (0,0),(0,1),(1,0),(1,1), each held 5 time units -> c = 1,0,0,1 and eq = 1,0,0,1, changing immediately with the inputs.
- WIDTH=8, rst=1 for one edge, then en=1 with a=8'hA5, b=8'hA5 -> c=8'hFF, eq=1. One edge later c_q=8'hFF, eq_q=1, match_cnt=1.
- WIDTH=8, en=1, a=8'hF0, b=8'h0F -> c=8'h00, eq=0. Next edge c_q=8'h00, eq_q=0, match_cnt unchanged.
- en=0 with a changing every cycle -> c tracks combinationally. c_q, eq_q and match_cnt hold their prior values.
- CNT_W=2, a==b, en=1 for 6 cycles after reset -> match_cnt goes 1,2,3,3,3,3 (saturates at 3).
- Assert rst while en=1, a==b, match_cnt=2 -> next edge match_cnt=0, c_q=0, eq_q=0. c still equals all-ones combinationally.
